// File: rtl/trap_peak_sampler.sv
// Pulse-height sampler behind the trapezoidal filter: threshold trigger, delayed flat-top
// capture, pile-up reject, shift/saturate, one AXI-Stream word per accepted event.
module trap_peak_sampler #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int OUT_WIDTH        = 16,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                               clk,
  input  logic                               areset,
  input  logic signed [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                               s_axis_tvalid,
  output logic signed [OUT_WIDTH-1:0]        m_axis_tdata,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  input  logic signed [31:0]                 threshold,
  input  logic [13:0]                        flat_delay,
  input  logic [13:0]                        holdoff,
  input  logic [4:0]                         shift,
  output logic [CNT_WIDTH-1:0]               event_count,
  output logic [CNT_WIDTH-1:0]               reject_count,
  output logic [CNT_WIDTH-1:0]               drop_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic signed [AXIS_TDATA_WIDTH-1:0] SAT_MAX =
    {{(AXIS_TDATA_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [AXIS_TDATA_WIDTH-1:0] SAT_MIN =
    {{(AXIS_TDATA_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  function automatic logic signed [OUT_WIDTH-1:0] sat_out(
    input logic signed [AXIS_TDATA_WIDTH-1:0] v);
    if (v > SAT_MAX)      sat_out = SAT_MAX[OUT_WIDTH-1:0];
    else if (v < SAT_MIN) sat_out = SAT_MIN[OUT_WIDTH-1:0];
    else                  sat_out = v[OUT_WIDTH-1:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
    cnt_inc = (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [1:0]                         r_state;
  logic [13:0]                        r_cnt;
  logic [13:0]                        r_flat;
  logic [13:0]                        r_hold;
  logic [4:0]                         r_shift;
  logic                               r_above_prev;
  logic signed [OUT_WIDTH-1:0]        r_tdata;
  logic                               r_tvalid;
  logic [CNT_WIDTH-1:0]               r_event;
  logic [CNT_WIDTH-1:0]               r_reject;
  logic [CNT_WIDTH-1:0]               r_drop;

  logic                               w_above;
  logic                               w_cross;
  logic [13:0]                        w_cnt_inc;
  logic [4:0]                         w_shamt;
  logic signed [AXIS_TDATA_WIDTH-1:0] w_shifted;
  logic signed [OUT_WIDTH-1:0]        w_sat;
  logic                               w_capture;

  assign w_above   = (s_axis_tdata > threshold);
  assign w_cross   = w_above && !r_above_prev;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 14'd1;
  // A zero-delay capture happens on the crossing sample itself, before the shift is latched.
  assign w_shamt   = (r_state == ST_IDLE) ? shift : r_shift;
  assign w_shifted = s_axis_tdata >>> w_shamt;
  assign w_sat     = sat_out(w_shifted);
  assign w_capture = s_axis_tvalid &&
                     (((r_state == ST_IDLE) && w_cross && (flat_delay == 14'd0)) ||
                      ((r_state == ST_WAIT) && w_above && (r_cnt == r_flat)));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_flat       <= '0;
      r_hold       <= '0;
      r_shift      <= '0;
      r_above_prev <= 1'b1;
      r_reject     <= '0;
    end else if (s_axis_tvalid) begin
      r_above_prev <= w_above;
      case (r_state)
        ST_IDLE: begin
          if (w_cross) begin
            r_flat  <= flat_delay;
            r_hold  <= holdoff;
            r_shift <= shift;
            if (flat_delay == 14'd0) begin
              r_state <= ST_HOLD;
              r_cnt   <= '0;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= 14'd1;
            end
          end
        end
        ST_WAIT: begin
          if (!w_above) begin
            r_reject <= cnt_inc(r_reject);
            r_state  <= ST_IDLE;
          end else if (r_cnt == r_flat) begin
            r_cnt   <= '0;
            r_state <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt + 14'd1;
          end
        end
        ST_HOLD: begin
          r_cnt <= w_cnt_inc;
          if ((w_cnt_inc >= r_hold) && !w_above) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output register: a capture loads only if the slot is empty or being drained this cycle.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_event  <= '0;
      r_drop   <= '0;
    end else begin
      if (w_capture) r_event <= cnt_inc(r_event);
      if (w_capture && (!r_tvalid || m_axis_tready)) begin
        r_tdata  <= w_sat;
        r_tvalid <= 1'b1;
      end else begin
        if (w_capture)     r_drop   <= cnt_inc(r_drop);
        if (m_axis_tready) r_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign event_count   = r_event;
  assign reject_count  = r_reject;
  assign drop_count    = r_drop;

endmodule

// File: tb/tb_trap_peak_sampler.sv
// Directed bench for trap_peak_sampler: table of capture/saturation vectors plus
// hand-written trigger, reject, backpressure and asynchronous reset sequences.
module tb_trap_peak_sampler;

  logic               clk = 1'b0;
  logic               areset;
  logic signed [31:0] s_tdata;
  logic               s_tvalid;
  logic signed [15:0] m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic signed [31:0] threshold;
  logic [13:0]        flat_delay;
  logic [13:0]        holdoff;
  logic [4:0]         shift;
  logic [31:0]        event_count;
  logic [31:0]        reject_count;
  logic [31:0]        drop_count;

  int total = 0;
  int bad   = 0;
  int xfer_cnt = 0;
  int last_xfer = 0;

  always #5 clk = ~clk;

  trap_peak_sampler dut (
    .clk           (clk),
    .areset        (areset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .threshold     (threshold),
    .flat_delay    (flat_delay),
    .holdoff       (holdoff),
    .shift         (shift),
    .event_count   (event_count),
    .reject_count  (reject_count),
    .drop_count    (drop_count)
  );

  always @(posedge clk) begin
    if (m_tvalid && m_tready) begin
      xfer_cnt  <= xfer_cnt + 1;
      last_xfer <= int'(m_tdata);
    end
  end

  typedef struct {
    logic signed [31:0] hi;
    logic signed [31:0] th;
    logic [4:0]         sh;
    logic signed [15:0] exp;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic signed [31:0] v);
    @(negedge clk);
    s_tdata  = v;
    s_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    @(negedge clk);
    areset = 1'b0;
  endtask

  task automatic cfg(input logic signed [31:0] th, input int fd, input int ho, input int sh);
    threshold  = th;
    flat_delay = 14'(fd);
    holdoff    = 14'(ho);
    shift      = 5'(sh);
  endtask

  vec_t tbl[12];
  int   q[$];
  int   first_idx;
  int   first_val;
  int   n_hi;
  int   x0;

  initial begin
    areset = 1'b1; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
    cfg(32'sd1000, 12, 4, 2);

    tbl[0]  = '{32'sd4000,      32'sd1000,      5'd2,  16'sd1000};
    tbl[1]  = '{32'sd40000000,  32'sd1000,      5'd0,  16'sd32767};
    tbl[2]  = '{-32'sd40000000, -32'sd50000000, 5'd0, -16'sd32768};
    tbl[3]  = '{32'sd40000000,  32'sd1000,      5'd12, 16'sd9765};
    tbl[4]  = '{-32'sd40000000, -32'sd50000000, 5'd12, -16'sd9766};
    tbl[5]  = '{32'sd32767,     32'sd0,         5'd0,  16'sd32767};
    tbl[6]  = '{32'sd32768,     32'sd0,         5'd0,  16'sd32767};
    tbl[7]  = '{-32'sd32768,    -32'sd40000,    5'd0, -16'sd32768};
    tbl[8]  = '{-32'sd32769,    -32'sd40000,    5'd0, -16'sd32768};
    tbl[9]  = '{32'sd2147483647, 32'sd0,        5'd31, 16'sd0};
    tbl[10] = '{-32'sd1000000,  -32'sd2000000,  5'd31, -16'sd1};
    tbl[11] = '{32'sd65536,     32'sd0,         5'd1,  16'sd32767};

    // reset state
    do_reset();
    chk("reset_tvalid", m_tvalid, 0);
    chk("reset_tdata", m_tdata, 0);
    chk("reset_event", event_count, 0);
    chk("reset_reject", reject_count, 0);
    chk("reset_drop", drop_count, 0);

    // single trapezoid
    for (int i = 0; i <= 8; i++) q.push_back(500 * i);
    for (int i = 0; i < 20; i++) q.push_back(4000);
    for (int i = 1; i <= 8; i++) q.push_back(4000 - 500 * i);
    first_idx = -1; first_val = 0; n_hi = 0;
    foreach (q[i]) begin
      send(q[i]);
      if (m_tvalid) begin
        if (first_idx < 0) begin first_idx = i; first_val = int'(m_tdata); end
        n_hi++;
      end
    end
    chk("trap_latency_idx", first_idx, 15);
    chk("trap_value", first_val, 1000);
    chk("trap_valid_cycles", n_hi, 1);
    chk("trap_event", event_count, 1);
    chk("trap_reject", reject_count, 0);

    // above threshold from reset must not trigger
    do_reset();
    cfg(32'sd1000, 3, 2, 2);
    n_hi = 0;
    for (int i = 0; i < 10; i++) begin send(32'sd5000); if (m_tvalid) n_hi++; end
    chk("flat_no_trigger", n_hi, 0);
    send(32'sd0); send(32'sd0);
    first_val = 0;
    for (int i = 0; i < 6; i++) begin
      send(32'sd5000);
      if (m_tvalid) begin n_hi++; first_val = int'(m_tdata); end
    end
    for (int i = 0; i < 3; i++) begin send(32'sd0); if (m_tvalid) n_hi++; end
    chk("flat_one_event", n_hi, 1);
    chk("flat_value", first_val, 1250);
    chk("flat_event", event_count, 1);

    // pile-up reject then re-arm
    do_reset();
    cfg(32'sd1000, 10, 2, 2);
    n_hi = 0;
    send(32'sd0); send(32'sd2000); send(32'sd2000); send(32'sd2000); send(32'sd0);
    chk("rej_count", reject_count, 1);
    chk("rej_no_event", event_count, 0);
    chk("rej_no_output", m_tvalid, 0);
    first_idx = -1;
    for (int i = 0; i < 12; i++) begin
      send(32'sd2000);
      if (m_tvalid && first_idx < 0) begin first_idx = i; first_val = int'(m_tdata); end
    end
    send(32'sd0);
    chk("rearm_idx", first_idx, 10);
    chk("rearm_value", first_val, 500);
    chk("rearm_event", event_count, 1);
    chk("rearm_reject", reject_count, 1);

    // backpressure: second capture dropped, first held
    do_reset();
    m_tready = 1'b0;
    cfg(32'sd1000, 2, 0, 0);
    send(32'sd0); send(32'sd3000); send(32'sd3000); send(32'sd3000);
    chk("bp_first_valid", m_tvalid, 1);
    chk("bp_first_data", m_tdata, 3000);
    send(32'sd0); send(32'sd0); send(32'sd7000); send(32'sd7000);
    chk("bp_hold_mid", m_tdata, 3000);
    send(32'sd7000); send(32'sd0);
    chk("bp_hold_data", m_tdata, 3000);
    chk("bp_hold_valid", m_tvalid, 1);
    chk("bp_drop", drop_count, 1);
    chk("bp_event", event_count, 2);
    x0 = xfer_cnt;
    m_tready = 1'b1;
    idle(1);
    chk("bp_drained", m_tvalid, 0);
    idle(3);
    chk("bp_xfer_once", xfer_cnt - x0, 1);
    chk("bp_xfer_value", last_xfer, 3000);

    // capture coinciding with an accepting handshake
    do_reset();
    m_tready = 1'b0;
    cfg(32'sd1000, 0, 0, 0);
    send(32'sd0); send(32'sd3000);
    chk("cc_first_data", m_tdata, 3000);
    send(32'sd0);
    x0 = xfer_cnt;
    m_tready = 1'b1;
    send(32'sd6000);
    chk("cc_new_data", m_tdata, 6000);
    chk("cc_valid", m_tvalid, 1);
    chk("cc_no_drop", drop_count, 0);
    chk("cc_event", event_count, 2);
    chk("cc_xfer", xfer_cnt - x0, 1);
    chk("cc_xfer_value", last_xfer, 3000);
    idle(2);

    // asynchronous reset in the middle of WAIT
    do_reset();
    m_tready = 1'b0;
    cfg(32'sd1000, 2, 0, 0);
    send(32'sd0); send(32'sd5000); send(32'sd5000); send(32'sd5000); send(32'sd0);
    flat_delay = 14'd10;
    send(32'sd5000); send(32'sd5000);
    chk("ar_pre_valid", m_tvalid, 1);
    areset = 1'b1;
    #1;
    chk("ar_valid", m_tvalid, 0);
    chk("ar_data", m_tdata, 0);
    chk("ar_event", event_count, 0);
    chk("ar_drop", drop_count, 0);
    chk("ar_reject", reject_count, 0);
    @(negedge clk);
    areset = 1'b0;
    n_hi = 0;
    for (int i = 0; i < 15; i++) begin send(32'sd5000); if (m_tvalid) n_hi++; end
    chk("ar_no_spurious", n_hi, 0);
    chk("ar_event_after", event_count, 0);

    // table of capture / shift / saturation vectors
    do_reset();
    m_tready = 1'b1;
    flat_delay = 14'd2;
    holdoff    = 14'd0;
    foreach (tbl[i]) begin
      threshold = tbl[i].th;
      shift     = tbl[i].sh;
      send(tbl[i].th - 32'sd1);
      send(tbl[i].hi);
      send(tbl[i].hi);
      chk($sformatf("vec%0d_early", i), m_tvalid, 0);
      send(tbl[i].hi);
      chk($sformatf("vec%0d_valid", i), m_tvalid, 1);
      chk($sformatf("vec%0d_data", i), m_tdata, tbl[i].exp);
      send(tbl[i].th - 32'sd1);
    end
    chk("vec_events", event_count, 12);
    chk("vec_drops", drop_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_peak_sampler.md
Name: trap_peak_sampler

Overview:
- Sits directly downstream of the trapezoidal filter and consumes its 32-bit signed result stream.
- Detects each trapezoid with a threshold crossing and samples its flat-top a programmable number of samples after the crossing.
- Rejects pile-up pulses, scales and saturates the pulse height, and presents one 16-bit pulse-height word per accepted event on an AXI-Stream master with full valid/ready handshake, for the histogrammer or DMA stage that follows.

Parameters:
- AXIS_TDATA_WIDTH, 32, input sample width (filter output width).
- OUT_WIDTH, 16, output pulse-height width.
- CNT_WIDTH, 32, width of the event, reject and drop counters.

Ports:
- clk  in  1  system clock.
- areset  in  1  reset, asynchronous, active-high.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  signed filter output.
- s_axis_tvalid  in  1  sample valid; no ready, the stream never stalls.
- m_axis_tdata  out  OUT_WIDTH  signed pulse height.
- m_axis_tvalid  out  1  pulse height valid.
- m_axis_tready  in  1  downstream ready.
- threshold  in  32  signed trigger level.
- flat_delay  in  14  valid samples from crossing to capture; typically K + (L-K)/2.
- holdoff  in  14  minimum valid samples after capture before re-arm.
- shift  in  5  arithmetic right-shift applied before saturation.
- event_count  out  CNT_WIDTH  accepted events.
- reject_count  out  CNT_WIDTH  pile-up rejects.
- drop_count  out  CNT_WIDTH  captures lost to output backpressure.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - areset asynchronously clears every register: state=IDLE; m_axis_tvalid=0; m_axis_tdata=0; all counters=0; wait/holdoff counter=0.
  - above_prev resets to 1, so a trace already above threshold after reset cannot trigger; it must first drop to or below threshold.
- Sample handling:
  - All sample-driven logic advances only on cycles with s_axis_tvalid=1.
  - Comparisons are signed, full 32-bit.
  - above = (s_axis_tdata > threshold).
  - A crossing is above=1 while above_prev=0.
  - above_prev updates on every valid sample, in every state.
- State IDLE:
  - On a crossing, latch flat_delay, holdoff and shift.
  - If flat_delay=0, capture this same sample and go to HOLDOFF.
  - Otherwise set cnt=1 and go to WAIT.
- State WAIT:
  - Each valid sample: if above=0, pile-up/undershoot occurred: reject_count++, go to IDLE, no capture.
  - Else if cnt == latched flat_delay: capture, cnt=0, go to HOLDOFF.
  - Else cnt++.
- State HOLDOFF:
  - Each valid sample: cnt++ (saturating).
  - Return to IDLE when cnt >= latched holdoff AND above=0 on the same sample.
  - Crossings in HOLDOFF are ignored.
- Capture:
  - value = s_axis_tdata >>> shift (arithmetic), saturated to the signed OUT_WIDTH range [-32768, 32767].
  - The result appears on m_axis_tdata with m_axis_tvalid=1 on the cycle after the capture sample (latency 1).
  - event_count++ on capture.
- Output handshake:
  - m_axis_tdata stays stable while m_axis_tvalid=1 and m_axis_tready=0.
  - The transfer completes on a cycle with m_axis_tvalid=1 and m_axis_tready=1; m_axis_tvalid drops next cycle unless a new capture loads.
  - Capture while the output is full and not being accepted: drop_count++, output unchanged, state machine proceeds normally.
  - Capture on the same cycle as an accepting handshake: new value loads, tvalid stays 1, no drop.
- Counters:
  - All counters saturate at all-ones and never wrap.
  - event_count counts captures, including dropped ones.
- Configuration changes mid-event take effect at the next IDLE crossing only.
- s_axis_tvalid=0 freezes sample-driven state; output handshake and counters remain live.

Test Plan:
- Reset then trapezoid (ramp 0→4000 over 8 samples, flat 20 samples, ramp down); threshold=1000, flat_delay=12, shift=2 → one output 1000, event_count=1, tvalid one cycle after capture sample.
- Flat input 5000 from reset, threshold=1000 → no output until the input drops to 0 and rises again; then exactly one event.
- Input crosses threshold, then falls below at sample 3 with flat_delay=10 → no output, reject_count=1, re-arms on the next crossing.
- Flat-top 40000000 with shift=0 → m_axis_tdata=32767; flat-top −40000000 with threshold=−50000000 → −32768.
- Hold m_axis_tready=0 across two events → first value held stable, drop_count=1, event_count=2; then ready=1 → first value transferred once.
- Assert areset mid-WAIT with m_axis_tvalid=1 → all outputs and counters 0 immediately (asynchronous), no spurious event while the input is still above threshold.
